// File: rtl/halo_addr_seq_v2_if.sv
// Halo-resolve address sequencer bus: controller-side start/stall and
// run configuration in, per-bank/port RAM address/enable vectors and
// busy/done/err status out. Master = system controller, slave = sequencer.
interface halo_addr_seq_v2_if #(
    parameter int LINWDTH = 9,
    parameter int ADDRLEN = 3,
    parameter int NUMTRG  = 3
);
    localparam int NB = 1 << ADDRLEN;
    localparam int W  = LINWDTH - ADDRLEN;

    logic                start;
    logic                stall;
    logic [NB-1:0]       cfg_en;
    logic [NB*W-1:0]     cfg_init_send;
    logic [NB*W-1:0]     cfg_last_send;
    logic [NB*W-1:0]     cfg_init_recv;
    logic [NB*W-1:0]     cfg_last_recv;
    logic [NUMTRG*W-1:0] cfg_incr_trg;
    logic [NUMTRG*W-1:0] cfg_incr_val;
    logic [W-1:0]        cfg_numiters;
    logic [W-1:0]        cfg_eof;
    logic [NB*2*W-1:0]   addr;
    logic [NB*2-1:0]     en_dp;
    logic [NB*2-1:0]     wren_dp;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, stall, cfg_en,
        output cfg_init_send, cfg_last_send,
        output cfg_init_recv, cfg_last_recv,
        output cfg_incr_trg, cfg_incr_val,
        output cfg_numiters, cfg_eof,
        input  addr, en_dp, wren_dp,
        input  busy, done, err
    );

    modport slave (
        input  start, stall, cfg_en,
        input  cfg_init_send, cfg_last_send,
        input  cfg_init_recv, cfg_last_recv,
        input  cfg_incr_trg, cfg_incr_val,
        input  cfg_numiters, cfg_eof,
        output addr, en_dp, wren_dp,
        output busy, done, err
    );
endinterface

// File: rtl/halo_addr_seq_v2.sv
// Halo-resolve address sequencer: walks per-bank send/recv offsets through
// an increment table, one lane per bank/port (lane = 2*bank + port).
// Ports: clk, reset (async, active-low), bus (slave side of
// halo_addr_seq_v2_if: start/stall/cfg_* in, addr/en_dp/wren_dp and
// busy/done/err out, all outputs registered).
module halo_addr_seq_v2 #(
    parameter int LINWDTH = 9,
    parameter int ADDRLEN = 3,
    parameter int NUMTRG  = 3,
    parameter int PLDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    halo_addr_seq_v2_if.slave bus
);
    localparam int NB = 1 << ADDRLEN;
    localparam int W  = LINWDTH - ADDRLEN;
    localparam int NL = 2 * NB;
    localparam int CW = $clog2(PLDEPTH + 1) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // shadow configuration, frozen for the whole run
    logic [NB-1:0]   en_cfg_q, en_cfg_d;
    logic [W-1:0]    init_q [NL];
    logic [W-1:0]    init_d [NL];
    logic [W-1:0]    last_q [NL];
    logic [W-1:0]    last_d [NL];
    logic [W-1:0]    trg_q [NUMTRG];
    logic [W-1:0]    trg_d [NUMTRG];
    logic [W-1:0]    val_q [NUMTRG];
    logic [W-1:0]    val_d [NUMTRG];
    logic [W-1:0]    numit_q, numit_d;
    logic [W-1:0]    eof_q, eof_d;

    // per-lane sequencing state
    logic [W-1:0]    iter_q [NL];
    logic [W-1:0]    iter_d [NL];
    logic [W-1:0]    base_q [NL];
    logic [W-1:0]    base_d [NL];
    logic [W-1:0]    off_q [NL];
    logic [W-1:0]    off_d [NL];

    logic [NL*W-1:0] addr_q, addr_d;
    logic [NL-1:0]   en_dp_q, en_dp_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [NL-1:0]   act;
    logic [W-1:0]    incr [NL];
    logic [W:0]      sum [NL];
    logic [W-1:0]    off_nx [NL];

    // lane activity and next offset, purely from the current lane state
    always_comb begin
        for (int l = 0; l < NL; l++) begin
            act[l] = en_cfg_q[l/2] && (iter_q[l] != numit_q);
            incr[l] = '0;
            // ascending scan so the highest matching entry wins;
            // entry 0 always matches and acts as the default
            for (int i = 0; i < NUMTRG; i++) begin
                if (i == 0 || off_q[l] > trg_q[i]) begin
                    incr[l] = val_q[i];
                end
            end
            sum[l] = {1'b0, off_q[l]} + {1'b0, incr[l]};
            if (sum[l] >= {1'b0, eof_q}) begin
                off_nx[l] = W'(sum[l] - {1'b0, eof_q});
            end else begin
                off_nx[l] = sum[l][W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_cfg_d = en_cfg_q;
        init_d   = init_q;
        last_d   = last_q;
        trg_d    = trg_q;
        val_d    = val_q;
        numit_d  = numit_q;
        eof_d    = eof_q;
        iter_d   = iter_q;
        base_d   = base_q;
        off_d    = off_q;
        addr_d   = addr_q;
        en_dp_d  = '0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                en_cfg_d = bus.cfg_en;
                numit_d  = bus.cfg_numiters;
                eof_d    = bus.cfg_eof;
                for (int i = 0; i < NUMTRG; i++) begin
                    trg_d[i] = bus.cfg_incr_trg[i*W +: W];
                    val_d[i] = bus.cfg_incr_val[i*W +: W];
                end
                for (int k = 0; k < NB; k++) begin
                    init_d[2*k]   = bus.cfg_init_send[k*W +: W];
                    last_d[2*k]   = bus.cfg_last_send[k*W +: W];
                    init_d[2*k+1] = bus.cfg_init_recv[k*W +: W];
                    last_d[2*k+1] = bus.cfg_last_recv[k*W +: W];
                    iter_d[2*k]   = '0;
                    base_d[2*k]   = '0;
                    off_d[2*k]    = bus.cfg_init_send[k*W +: W];
                    iter_d[2*k+1] = '0;
                    base_d[2*k+1] = '0;
                    off_d[2*k+1]  = bus.cfg_init_recv[k*W +: W];
                end
                if (bus.cfg_eof == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (bus.cfg_en == '0 ||
                             bus.cfg_numiters == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (act == '0) begin
                    cnt_d = CW'(1);
                    if (PLDEPTH == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (!bus.stall) begin
                    for (int l = 0; l < NL; l++) begin
                        if (act[l]) begin
                            addr_d[l*W +: W] = base_q[l] + off_q[l];
                            en_dp_d[l]       = 1'b1;
                            if (off_q[l] != last_q[l]) begin
                                off_d[l] = off_nx[l];
                            end else begin
                                iter_d[l] = iter_q[l] + 1'b1;
                                base_d[l] = base_q[l] + eof_q;
                                off_d[l]  = init_q[l];
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(PLDEPTH)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) ||
                 (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            en_cfg_q <= '0;
            numit_q  <= '0;
            eof_q    <= '0;
            for (int i = 0; i < NUMTRG; i++) begin
                trg_q[i] <= '0;
                val_q[i] <= '0;
            end
            for (int l = 0; l < NL; l++) begin
                init_q[l] <= '0;
                last_q[l] <= '0;
                iter_q[l] <= '0;
                base_q[l] <= '0;
                off_q[l]  <= '0;
            end
            addr_q  <= '0;
            en_dp_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_cfg_q <= en_cfg_d;
            numit_q  <= numit_d;
            eof_q    <= eof_d;
            trg_q    <= trg_d;
            val_q    <= val_d;
            init_q   <= init_d;
            last_q   <= last_d;
            iter_q   <= iter_d;
            base_q   <= base_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            en_dp_q  <= en_dp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.en_dp   = en_dp_q;
    assign bus.wren_dp = en_dp_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_halo_addr_seq_v2.sv
// Directed bench for halo_addr_seq_v2: drives at negedge, samples at
// negedge, compares traced lanes against hand-computed sequences.
module tb_halo_addr_seq_v2;
    localparam int LINWDTH = 9;
    localparam int ADDRLEN = 3;
    localparam int NUMTRG  = 3;
    localparam int PLDEPTH = 2;
    localparam int NB = 1 << ADDRLEN;
    localparam int W  = LINWDTH - ADDRLEN;
    localparam int NL = 2 * NB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    halo_addr_seq_v2_if #(
        .LINWDTH(LINWDTH), .ADDRLEN(ADDRLEN), .NUMTRG(NUMTRG)
    ) bus ();

    halo_addr_seq_v2 #(
        .LINWDTH(LINWDTH), .ADDRLEN(ADDRLEN),
        .NUMTRG(NUMTRG), .PLDEPTH(PLDEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [NL-1:0]   en_tr   [64];
    logic [NL*W-1:0] ad_tr   [64];
    logic            busy_tr [64];
    logic            err_tr  [64];
    int done_t, done_cnt, wr_bad, en_tot;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [W-1:0] la(input int t, input int l);
        logic [NL*W-1:0] v;
        v = ad_tr[t];
        return v[l*W +: W];
    endfunction

    task automatic set_lane(input int k, input logic [W-1:0] is,
                            input logic [W-1:0] ls, input logic [W-1:0] ir,
                            input logic [W-1:0] lr);
        bus.cfg_init_send[k*W +: W] = is;
        bus.cfg_last_send[k*W +: W] = ls;
        bus.cfg_init_recv[k*W +: W] = ir;
        bus.cfg_last_recv[k*W +: W] = lr;
    endtask

    task automatic cfg_basic();
        bus.cfg_eof      = 6'd5;
        bus.cfg_numiters = 6'd2;
        bus.cfg_en       = 8'hFF;
        bus.cfg_incr_val = {6'd2, 6'd2, 6'd2};
        bus.cfg_incr_trg = {6'd0, 6'd0, 6'd0};
        for (int k = 0; k < NB; k++) set_lane(k, 0, 2, 1, 3);
        set_lane(1, 0, 0, 1, 3);
    endtask

    task automatic run(input int st_t, input int st_n, input bit hold,
                       input bit scramble);
        for (int t = 0; t < 64; t++) begin
            en_tr[t] = '0; ad_tr[t] = '0;
            busy_tr[t] = 1'b0; err_tr[t] = 1'b0;
        end
        done_t = -1; done_cnt = 0; wr_bad = 0; en_tot = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t < 64; t++) begin
            @(negedge clk);
            en_tr[t]   = bus.en_dp;
            ad_tr[t]   = bus.addr;
            busy_tr[t] = bus.busy;
            err_tr[t]  = bus.err;
            if (bus.wren_dp !== bus.en_dp) wr_bad++;
            if (bus.en_dp != '0) en_tot++;
            if (bus.done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (!hold) bus.start = 1'b0;
            bus.stall = (t >= st_t) && (t < st_t + st_n);
            if (scramble && t == 2) begin
                bus.cfg_eof = 6'd7;
                bus.cfg_numiters = 6'd5;
                bus.cfg_incr_val = '0;
            end
            if (done_t >= 0 && t >= done_t + (hold ? 5 : 2)) break;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.cfg_init_send = '0; bus.cfg_last_send = '0;
        bus.cfg_init_recv = '0; bus.cfg_last_recv = '0;
        cfg_basic();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_en", bus.en_dp, 0);
        chk("rst_wren", bus.wren_dp, 0);
        chk("rst_addr_lo", bus.addr[31:0], 0);
        reset = 1'b1;

        // basic sequencing, cfg changed mid-run
        cfg_basic();
        run(-10, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] e0 [4] = '{0, 2, 5, 7};
            logic [W-1:0] e1 [4] = '{1, 3, 6, 8};
            chk($sformatf("bas_a0_%0d", i), la(3+i, 0), e0[i]);
            chk($sformatf("bas_a1_%0d", i), la(3+i, 1), e1[i]);
            chk($sformatf("bas_en0_%0d", i), en_tr[3+i][0], 1);
        end
        chk("bas_en0_off", en_tr[7][0], 0);
        chk("bas_b1_a0", la(3, 2), 0);
        chk("bas_b1_a1", la(4, 2), 5);
        chk("bas_b1_off", en_tr[5][2], 0);
        chk("bas_b1r_on", en_tr[5][3], 1);
        chk("bas_done_t", done_t, 9);
        chk("bas_done_cnt", done_cnt, 1);
        chk("bas_wren", wr_bad, 0);
        chk("bas_busy_load", busy_tr[1], 1);
        chk("bas_busy_drain", busy_tr[8], 1);
        chk("bas_busy_done", busy_tr[9], 0);
        chk("bas_err", err_tr[9], 0);

        // wrap-around
        cfg_basic();
        bus.cfg_incr_val = {6'd3, 6'd3, 6'd3};
        for (int k = 0; k < NB; k++) set_lane(k, 3, 1, 3, 1);
        run(-10, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ew [4] = '{3, 1, 8, 6};
            chk($sformatf("wrap_a0_%0d", i), la(3+i, 0), ew[i]);
            chk($sformatf("wrap_a1_%0d", i), la(3+i, 1), ew[i]);
        end
        chk("wrap_done_t", done_t, 9);

        // increment table: val {2:22,1:22,0:7}, trg {2:3,1:3}
        cfg_basic();
        bus.cfg_en = 8'h01;
        bus.cfg_eof = 6'd25;
        bus.cfg_numiters = 6'd1;
        bus.cfg_incr_val = {6'd22, 6'd22, 6'd7};
        bus.cfg_incr_trg = {6'd3, 6'd3, 6'd0};
        for (int k = 0; k < NB; k++) set_lane(k, 0, 2, 0, 2);
        run(-10, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            logic [W-1:0] et [7] = '{0, 7, 4, 1, 8, 5, 2};
            chk($sformatf("tab_a0_%0d", i), la(3+i, 0), et[i]);
        end
        chk("tab_en0_off", en_tr[10][0], 0);
        chk("tab_bank1_off", en_tr[3][2], 0);
        chk("tab_done_t", done_t, 12);

        // stall for two cycles after the second address
        cfg_basic();
        run(4, 2, 0, 0);
        chk("stl_en_a", en_tr[5][0], 0);
        chk("stl_en_b", en_tr[6][0], 0);
        chk("stl_hold_a", la(5, 0), 2);
        chk("stl_hold_b", la(6, 0), 2);
        chk("stl_resume", la(7, 0), 5);
        chk("stl_last", la(8, 0), 7);
        chk("stl_done_t", done_t, 11);

        // eof == 0
        cfg_basic();
        bus.cfg_eof = 6'd0;
        run(-10, 0, 0, 0);
        chk("eof0_done_t", done_t, 2);
        chk("eof0_err", err_tr[2], 1);
        chk("eof0_err_idle", err_tr[3], 1);
        chk("eof0_en", en_tot, 0);

        // no banks enabled; err from previous run clears at LOAD
        cfg_basic();
        bus.cfg_en = 8'h00;
        run(-10, 0, 0, 0);
        chk("en0_err_clr", err_tr[1], 0);
        chk("en0_done_t", done_t, 2);
        chk("en0_err", err_tr[2], 0);
        chk("en0_en", en_tot, 0);

        // numiters == 0
        cfg_basic();
        bus.cfg_numiters = 6'd0;
        run(-10, 0, 0, 0);
        chk("nit0_done_t", done_t, 2);
        chk("nit0_err", err_tr[2], 0);
        chk("nit0_en", en_tot, 0);

        // start held high: next run only after returning to IDLE
        cfg_basic();
        run(-10, 0, 1, 0);
        chk("hold_done_t", done_t, 9);
        chk("hold_idle", busy_tr[10], 0);
        chk("hold_reload", busy_tr[11], 1);
        chk("hold_2nd_a0", la(13, 0), 0);
        chk("hold_2nd_en", en_tr[13][0], 1);
        cnt = 0;
        for (int t = 0; t < 40 && cnt == 0; t++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("hold_2nd_done", cnt, 1);

        // reset in the middle of RUN
        cfg_basic();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_pre_en", bus.en_dp[0], 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_en", bus.en_dp, 0);
        chk("mid_addr_lo", bus.addr[31:0], 0);
        chk("mid_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.en_dp != '0) cnt++;
        end
        chk("mid_no_done", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
